// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation select values,
// controller state encoding and small decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        DIV_RUN = 3'd2,
        DIV_FIX = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Bit 1 of the encoding separates divides from multiplies.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // Bit 0 of the encoding marks the unsigned variants.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// Restoring radix-2 divider: captures operand magnitudes on load, retires one
// quotient bit per step, and presents sign-corrected quotient/remainder.
module div_radix2
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  op_e          op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         last_step,
    output logic         divisor_zero,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dz_q, dz_d;
    logic          sgn;
    logic [W:0]    rem_shift;
    logic [W:0]    diff;

    // Load magnitudes and sign fixup flags, then shift/subtract once per step.
    // A zero divisor keeps the quotient un-negated so it stays all ones, and
    // the remainder then naturally ends up equal to the original dividend.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        sgn       = op_is_signed(op);
        rem_shift = {rem_q, quo_q[W-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (load) begin
            rem_d  = '0;
            quo_d  = (sgn && dividend[W-1]) ? -dividend : dividend;
            dvs_d  = (sgn && divisor[W-1]) ? -divisor : divisor;
            cnt_d  = '0;
            dz_d   = (divisor == '0);
            rneg_d = sgn && dividend[W-1];
            qneg_d = sgn && (dividend[W-1] ^ divisor[W-1]) && (divisor != '0);
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    // Sign fixup: quotient negated on mixed signs, remainder follows the dividend.
    always_comb begin
        last_step    = (cnt_q == CW'(W - 1));
        divisor_zero = dz_q;
        quotient     = qneg_q ? -quo_q : quo_q;
        remainder    = rneg_q ? -rem_q : rem_q;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: controller FSM, MUL_LAT-deep multiply pipeline and the
// held result registers; the iterative divide datapath lives in div_radix2.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           div_zero
);

    // Register stages between the accept edge and the result register.
    localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    state_e           state_q, state_d;
    op_e              op_in;
    logic             accept;
    logic             mul_accept;
    logic             div_load;
    logic             div_step;
    logic [2*W-1:0]   ext_a, ext_b, prod;
    logic [2*W-1:0]   pipe_q [PD];
    logic [2*W-1:0]   pipe_d [PD];
    logic [PD-1:0]    vld_q, vld_d;
    logic             mul_out_vld;
    logic [2*W-1:0]   mul_out;
    logic [2*W-1:0]   result_q, result_d;
    logic             dz_q, dz_d;
    logic             div_last;
    logic             div_dz;
    logic [W-1:0]     div_quo, div_rem;

    // Accept decode and the extended full-width product of the raw operands,
    // which the first pipeline stage captures on the accept edge.
    always_comb begin
        op_in      = op_e'(op);
        accept     = (state_q == IDLE) && start && !flush;
        mul_accept = accept && !op_is_div(op_in);
        div_load   = accept && op_is_div(op_in);
        div_step   = (state_q == DIV_RUN);
        if (op_is_signed(op_in)) begin
            ext_a = {{W{src_a[W-1]}}, src_a};
            ext_b = {{W{src_b[W-1]}}, src_b};
        end else begin
            ext_a = {{W{1'b0}}, src_a};
            ext_b = {{W{1'b0}}, src_b};
        end
        prod = ext_a * ext_b;
    end

    // Multiply pipeline shift; flush drops every valid bit in flight.
    always_comb begin
        pipe_d[0] = mul_accept ? prod : pipe_q[0];
        vld_d[0]  = mul_accept;
        for (int i = 1; i < PD; i++) begin
            pipe_d[i] = pipe_q[i-1];
            vld_d[i]  = vld_q[i-1] && !flush;
        end
        if (MUL_LAT == 1) begin
            mul_out_vld = mul_accept;
            mul_out     = prod;
        end else begin
            mul_out_vld = vld_q[PD-1];
            mul_out     = pipe_q[PD-1];
        end
    end

    // Result/div_zero only change on the edge that leads into a done cycle.
    always_comb begin
        result_d = result_q;
        dz_d     = dz_q;
        if (!flush) begin
            if (mul_out_vld) begin
                result_d = mul_out;
                dz_d     = 1'b0;
            end else if (state_q == DIV_FIX) begin
                result_d = {div_rem, div_quo};
                dz_d     = div_dz;
            end
        end
    end

    // Datapath registers: multiply pipeline, valid bits and held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= '0;
            end
            vld_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            vld_q    <= vld_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a single-cycle multiply skips the MUL state entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (div_load) begin
                    state_d = DIV_RUN;
                end else if (mul_accept) begin
                    state_d = (MUL_LAT == 1) ? DONE : MUL;
                end
            end
            MUL:     if (mul_out_vld) state_d = DONE;
            DIV_RUN: if (div_last) state_d = DIV_FIX;
            DIV_FIX: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy     = (state_q == MUL) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
        done     = (state_q == DONE);
        result   = result_q;
        div_zero = dz_q;
    end

    div_radix2 #(
        .W(W)
    ) u_div (
        .clk          (clk),
        .rst          (rst),
        .load         (div_load),
        .step         (div_step),
        .op           (op_in),
        .dividend     (src_a),
        .divisor      (src_b),
        .last_step    (div_last),
        .divisor_zero (div_dz),
        .quotient     (div_quo),
        .remainder    (div_rem)
    );

endmodule
